ysyx_22040386_csr: RTL and testbench
====================================

# ysyx_22040386_csr

Machine-mode CSR file and trap unit for the single-cycle core, sitting directly downstream of instruction decode. It consumes the decoded CSR state, address and funct3 plus the rs1 value and PC. It holds the machine CSRs and a free-running `mcycle` counter, and executes `csrrw`/`csrrs` writes. It sequences `ecall`, `mret` and CLINT timer-interrupt entry, and gives the fetch stage a redirect target in the same cycle.

## Interface
- `XLEN`, 64, data/PC width
- `i_CSR_clk  in  1`  core clock
- `i_CSR_rst  in  1`  reset, synchronous, active-high
- `i_CSR_valid  in  1`  an instruction commits this cycle; when low, no CSR side effects except `mcycle` and `mip`
- `i_CSR_state  in  2`  00 IDLE, 01 RW, 10 ECALL, 11 MRET
- `i_CSR_funct3  in  3`  001 csrrw, 010 csrrs; other values write nothing
- `i_CSR_addr  in  12`  CSR address, used for both read and write
- `i_CSR_rs1_data  in  XLEN`  write source operand
- `i_CSR_pc  in  XLEN`  PC of the committing instruction
- `i_CSR_timer_irq  in  1`  level timer interrupt from CLINT
- `o_CSR_rdata  out  XLEN`  pre-write value of the addressed CSR, combinational; 0 for unmapped addresses
- `o_CSR_redirect  out  1`  next PC is taken from `o_CSR_redirect_pc`
- `o_CSR_redirect_pc  out  XLEN`  trap or return target
- `o_CSR_irq_taken  out  1`  the current instruction is squashed by an interrupt; the core suppresses its register and memory writes

## Operation
- Implemented CSRs: `mstatus` 0x300, `mie` 0x304, `mtvec` 0x305, `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mip` 0x344, `mcycle` 0xb00. All are 64-bit.
- Reset values: `mstatus` = 0x1800 (MPP=11); every other CSR = 0.
  - All outputs follow from these values combinationally, so after reset `o_CSR_redirect` = 0 and `o_CSR_irq_taken` = 0.
- `mip`: bit 7 (MTIP) is loaded from `i_CSR_timer_irq` every cycle. Software writes to `mip` are ignored.
- `mcycle`: increments by 1 every cycle that is not in reset, and wraps from 2^64−1 to 0.
  - A committed write to `mcycle` takes precedence over the increment for that cycle; the written value is loaded, not written+1.
- Interrupt condition, `irq` = valid & mstatus.MIE(bit 3) & mie.MTIE(bit 7) & mip.MTIP. This has the highest priority. When `irq` is true:
  - the instruction's own CSR action is discarded;
  - `mepc` ← pc;
  - `mcause` ← 0x8000_0000_0000_0007;
  - MPIE(bit 7) ← MIE, MIE ← 0, MPP ← 11;
  - redirect to `mtvec` & ~3;
  - `o_CSR_irq_taken` = 1.
- ECALL (valid, no `irq`):
  - `mepc` ← pc;
  - `mcause` ← 11;
  - same `mstatus` update as an interrupt;
  - redirect to `mtvec` & ~3.
- MRET (valid, no `irq`):
  - MIE ← MPIE, MPIE ← 1, MPP ← 11;
  - redirect to current `mepc`.
- RW (valid, no `irq`):
  - new value = rs1 for funct3 001; old | rs1 for funct3 010.
  - The write lands at the clock edge.
  - `o_CSR_rdata` always shows the old value.
  - Writes to unmapped addresses are dropped.
- IDLE or `!valid`: the CSR file holds state, and `o_CSR_redirect` = 0.

## Timing
- Reads, redirect and `irq_taken` are combinational from registered state and the current inputs.
- All CSR updates take effect at the next rising edge, so a CSR read in the following cycle sees the new value.
- The redirect PC uses the pre-edge `mtvec`/`mepc`. For example, an MRET in the cycle after an `mepc` write returns to the written value.
- MTIP sampling adds 1 cycle of latency: a timer assertion at edge N is visible in `mip` and can trap at edge N+1.
- Reset asserted mid-operation: at the next edge all CSRs return to their reset values regardless of the other inputs. Reset has priority over writes, traps and the increment.

## Structure
- Shared package holds:
  - CSR address constants;
  - `CSR_STATE_*` encodings;
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11);
  - mcause constants (ECALL_M=11, MTI=0x8000_0000_0000_0007).
- One natural sub-module: `ysyx_22040386_csr_trap_ctrl`. It is combinational and performs priority resolution (irq > ECALL/MRET > RW), producing per-CSR write enables and next values. The top level holds the registers and the counter.

## Test plan
- Reset, then idle for 10 cycles → `mcycle` = 10, `mstatus` = 0x1800, redirect = 0.
- csrrw to 0x305 with 0x8000_0100, then ECALL at pc 0x8000_0040 → redirect_pc = 0x8000_0100, `mepc` = 0x8000_0040, `mcause` = 11, MIE = 0, MPIE equal to the prior MIE.
- csrrs on 0x300 with 0x8 (MIE = 1), then MRET with `mepc` = 0x8000_0044 → redirect_pc = 0x8000_0044, MIE restored from MPIE, MPIE = 1.
- MIE = 1, MTIE = 1, `i_CSR_timer_irq` rises while a csrrw to 0x340 commits → `irq_taken` = 1, `mscratch` unchanged, `mcause` = 0x8000_0000_0000_0007.
- csrrw `mcycle` = 2^64−1 → next cycle `mcycle` = 2^64−1, then 0 the cycle after; a csrrw to `mip` with all-ones leaves only MTIP tracking the input.
- Assert reset during an ECALL cycle → all CSRs at reset values after the edge, `mepc` = 0.

Source files
------------

// File: rtl/ysyx_22040386_csr_pkg.sv
// rtl/ysyx_22040386_csr_pkg.sv - shared constants and types for the machine-mode CSR file
// Purpose: CSR addresses, CSR_STATE_* decode encodings, mstatus/mip bit indices,
//          mcause values and the per-CSR write request type used by top and trap_ctrl.
// Ports:   none (package).
package ysyx_22040386_csr_pkg;

   localparam int CSR_XLEN = 64;
   typedef logic [CSR_XLEN-1:0] csr_t;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hb00;

   typedef enum logic [1:0] {
      CSR_STATE_IDLE  = 2'b00,
      CSR_STATE_RW    = 2'b01,
      CSR_STATE_ECALL = 2'b10,
      CSR_STATE_MRET  = 2'b11
   } csr_state_e;

   localparam logic [2:0] F3_CSRRW = 3'b001;
   localparam logic [2:0] F3_CSRRS = 3'b010;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MTIE       = 7;
   localparam int MIP_MTIP       = 7;

   localparam csr_t MSTATUS_RESET = 64'h0000_0000_0000_1800;
   localparam csr_t MCAUSE_ECALL_M = 64'd11;
   localparam csr_t MCAUSE_MTI     = 64'h8000_0000_0000_0007;

   typedef struct packed {
      logic we;
      csr_t data;
   } csr_wr_t;

endpackage

// File: rtl/ysyx_22040386_csr_trap_ctrl.sv
// rtl/ysyx_22040386_csr_trap_ctrl.sv - priority resolution of interrupt, ecall, mret and csr writes
// Purpose: combinational; picks the single winning action (irq > ECALL/MRET > RW) and
//          produces per-CSR write requests plus the fetch redirect.
// Ports:   valid/state/funct3/addr/rs1_data/pc - decoded instruction
//          rdata_old - pre-write value of the addressed CSR (source for csrrs)
//          mstatus/mtvec/mepc/mtie/mtip - current CSR state
//          irq, redirect, redirect_pc - trap decision and target
//          wr_* - write enable and next value for each writable CSR
module ysyx_22040386_csr_trap_ctrl
   import ysyx_22040386_csr_pkg::*;
(
   input  logic        valid,
   input  logic [1:0]  state,
   input  logic [2:0]  funct3,
   input  logic [11:0] addr,
   input  csr_t        rs1_data,
   input  csr_t        pc,
   input  csr_t        rdata_old,
   input  csr_t        mstatus,
   input  csr_t        mtvec,
   input  csr_t        mepc,
   input  logic        mtie,
   input  logic        mtip,
   output logic        irq,
   output logic        redirect,
   output csr_t        redirect_pc,
   output csr_wr_t     wr_mstatus,
   output csr_wr_t     wr_mie,
   output csr_wr_t     wr_mtvec,
   output csr_wr_t     wr_mscratch,
   output csr_wr_t     wr_mepc,
   output csr_wr_t     wr_mcause,
   output csr_wr_t     wr_mcycle
);

   csr_t trap_mstatus;
   csr_t mret_mstatus;
   csr_t rw_data;
   logic rw_en;

   always_comb begin
      irq = valid & mstatus[MSTATUS_MIE] & mtie & mtip;

      // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M.
      trap_mstatus = mstatus;
      trap_mstatus[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      trap_mstatus[MSTATUS_MIE] = 1'b0;
      trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      mret_mstatus = mstatus;
      mret_mstatus[MSTATUS_MIE] = mstatus[MSTATUS_MPIE];
      mret_mstatus[MSTATUS_MPIE] = 1'b1;
      mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      rw_en = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRS);
      rw_data = (funct3 == F3_CSRRW) ? rs1_data : (rdata_old | rs1_data);

      redirect = 1'b0;
      redirect_pc = '0;
      wr_mstatus = '0;
      wr_mie = '0;
      wr_mtvec = '0;
      wr_mscratch = '0;
      wr_mepc = '0;
      wr_mcause = '0;
      wr_mcycle = '0;

      if (irq) begin
         redirect = 1'b1;
         redirect_pc = mtvec & ~csr_t'(3);
         wr_mepc = '{we: 1'b1, data: pc};
         wr_mcause = '{we: 1'b1, data: MCAUSE_MTI};
         wr_mstatus = '{we: 1'b1, data: trap_mstatus};
      end else if (valid) begin
         case (csr_state_e'(state))
            CSR_STATE_ECALL: begin
               redirect = 1'b1;
               redirect_pc = mtvec & ~csr_t'(3);
               wr_mepc = '{we: 1'b1, data: pc};
               wr_mcause = '{we: 1'b1, data: MCAUSE_ECALL_M};
               wr_mstatus = '{we: 1'b1, data: trap_mstatus};
            end
            CSR_STATE_MRET: begin
               redirect = 1'b1;
               redirect_pc = mepc;
               wr_mstatus = '{we: 1'b1, data: mret_mstatus};
            end
            CSR_STATE_RW: begin
               // mip and unmapped addresses fall through the case and are dropped.
               if (rw_en) begin
                  case (addr)
                     CSR_MSTATUS:  wr_mstatus = '{we: 1'b1, data: rw_data};
                     CSR_MIE:      wr_mie = '{we: 1'b1, data: rw_data};
                     CSR_MTVEC:    wr_mtvec = '{we: 1'b1, data: rw_data};
                     CSR_MSCRATCH: wr_mscratch = '{we: 1'b1, data: rw_data};
                     CSR_MEPC:     wr_mepc = '{we: 1'b1, data: rw_data};
                     CSR_MCAUSE:   wr_mcause = '{we: 1'b1, data: rw_data};
                     CSR_MCYCLE:   wr_mcycle = '{we: 1'b1, data: rw_data};
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_22040386_csr.sv
// rtl/ysyx_22040386_csr.sv - machine-mode CSR file, mcycle counter and trap sequencing
// Purpose: holds the machine CSRs, samples the CLINT timer into mip, counts mcycle and
//          applies the write requests chosen by ysyx_22040386_csr_trap_ctrl.
// Ports:   i_CSR_clk/i_CSR_rst - clock, synchronous active-high reset
//          i_CSR_valid/state/funct3/addr/rs1_data/pc - committing instruction
//          i_CSR_timer_irq - level timer interrupt
//          o_CSR_rdata - pre-write value of the addressed CSR
//          o_CSR_redirect/o_CSR_redirect_pc - fetch redirect
//          o_CSR_irq_taken - instruction squashed by an interrupt
module ysyx_22040386_csr
   import ysyx_22040386_csr_pkg::*;
#(
   parameter int XLEN = CSR_XLEN
) (
   input  logic            i_CSR_clk,
   input  logic            i_CSR_rst,
   input  logic            i_CSR_valid,
   input  logic [1:0]      i_CSR_state,
   input  logic [2:0]      i_CSR_funct3,
   input  logic [11:0]     i_CSR_addr,
   input  logic [XLEN-1:0] i_CSR_rs1_data,
   input  logic [XLEN-1:0] i_CSR_pc,
   input  logic            i_CSR_timer_irq,
   output logic [XLEN-1:0] o_CSR_rdata,
   output logic            o_CSR_redirect,
   output logic [XLEN-1:0] o_CSR_redirect_pc,
   output logic            o_CSR_irq_taken
);

   csr_t mstatus, mie, mtvec, mscratch, mepc, mcause, mip, mcycle;
   csr_t rdata;
   csr_wr_t wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mcycle;

   always_comb begin
      rdata = '0;
      case (i_CSR_addr)
         CSR_MSTATUS:  rdata = mstatus;
         CSR_MIE:      rdata = mie;
         CSR_MTVEC:    rdata = mtvec;
         CSR_MSCRATCH: rdata = mscratch;
         CSR_MEPC:     rdata = mepc;
         CSR_MCAUSE:   rdata = mcause;
         CSR_MIP:      rdata = mip;
         CSR_MCYCLE:   rdata = mcycle;
         default:      rdata = '0;
      endcase
   end

   assign o_CSR_rdata = rdata;

   ysyx_22040386_csr_trap_ctrl u_trap_ctrl (
      .valid       (i_CSR_valid),
      .state       (i_CSR_state),
      .funct3      (i_CSR_funct3),
      .addr        (i_CSR_addr),
      .rs1_data    (i_CSR_rs1_data),
      .pc          (i_CSR_pc),
      .rdata_old   (rdata),
      .mstatus     (mstatus),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .mtie        (mie[MIE_MTIE]),
      .mtip        (mip[MIP_MTIP]),
      .irq         (o_CSR_irq_taken),
      .redirect    (o_CSR_redirect),
      .redirect_pc (o_CSR_redirect_pc),
      .wr_mstatus  (wr_mstatus),
      .wr_mie      (wr_mie),
      .wr_mtvec    (wr_mtvec),
      .wr_mscratch (wr_mscratch),
      .wr_mepc     (wr_mepc),
      .wr_mcause   (wr_mcause),
      .wr_mcycle   (wr_mcycle)
   );

   always_ff @(posedge i_CSR_clk) begin
      if (i_CSR_rst) begin
         mstatus  <= MSTATUS_RESET;
         mie      <= '0;
         mtvec    <= '0;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mip      <= '0;
         mcycle   <= '0;
      end else begin
         if (wr_mstatus.we)  mstatus  <= wr_mstatus.data;
         if (wr_mie.we)      mie      <= wr_mie.data;
         if (wr_mtvec.we)    mtvec    <= wr_mtvec.data;
         if (wr_mscratch.we) mscratch <= wr_mscratch.data;
         if (wr_mepc.we)     mepc     <= wr_mepc.data;
         if (wr_mcause.we)   mcause   <= wr_mcause.data;
         // Only MTIP is backed by state; it mirrors the timer line one edge late.
         mip           <= '0;
         mip[MIP_MTIP] <= i_CSR_timer_irq;
         // A software write replaces the count outright rather than being incremented.
         mcycle <= wr_mcycle.we ? wr_mcycle.data : mcycle + csr_t'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_22040386_csr.sv
// tb/tb_ysyx_22040386_csr.sv - scoreboard bench for the machine-mode CSR file
module tb_ysyx_22040386_csr;

   logic        clk = 1'b0;
   logic        rst, valid, timer;
   logic [1:0]  state;
   logic [2:0]  funct3;
   logic [11:0] addr;
   logic [63:0] rs1, pc;
   logic [63:0] rdata, redirect_pc;
   logic        redirect, irq_taken;

   always #5 clk = ~clk;

   ysyx_22040386_csr dut (
      .i_CSR_clk         (clk),
      .i_CSR_rst         (rst),
      .i_CSR_valid       (valid),
      .i_CSR_state       (state),
      .i_CSR_funct3      (funct3),
      .i_CSR_addr        (addr),
      .i_CSR_rs1_data    (rs1),
      .i_CSR_pc          (pc),
      .i_CSR_timer_irq   (timer),
      .o_CSR_rdata       (rdata),
      .o_CSR_redirect    (redirect),
      .o_CSR_redirect_pc (redirect_pc),
      .o_CSR_irq_taken   (irq_taken)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        redirect;
      logic [63:0] rpc;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   exp_t me;
   logic [63:0] m [logic [11:0]];
   int total = 0;
   int bad = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, got, want);
      end
   endtask

   function automatic void model_reset();
      m[12'h300] = 64'h1800;
      m[12'h304] = 0; m[12'h305] = 0; m[12'h340] = 0;
      m[12'h341] = 0; m[12'h342] = 0; m[12'h344] = 0; m[12'hb00] = 0;
   endfunction

   // Drive one cycle; model state is what the CSRs hold before the coming edge.
   task automatic issue(input logic r, input logic v, input logic [1:0] st, input logic [2:0] f3,
                        input logic [11:0] a, input logic [63:0] d, input logic [63:0] p,
                        input logic t, input int sel, input logic [63:0] want, input string nm);
      exp_t e;
      logic [63:0] nxt [logic [11:0]];
      logic [63:0] ms;
      logic irq_c, trap;
      rst = r; valid = v; state = st; funct3 = f3; addr = a; rs1 = d; pc = p; timer = t;
      irq_c = v && m[12'h300][3] && m[12'h304][7] && m[12'h344][7];
      trap = irq_c || (v && st == 2'd2);
      e.rdata = m.exists(a) ? m[a] : 64'd0;
      e.irq = irq_c;
      e.redirect = v && (irq_c || st == 2'd2 || st == 2'd3);
      e.rpc = trap ? (m[12'h305] & ~64'd3) : m[12'h341];
      exp_q.push_back(e);

      nxt = m;
      nxt[12'hb00] = m[12'hb00] + 64'd1;
      nxt[12'h344] = t ? 64'h80 : 64'h0;
      ms = m[12'h300];
      if (trap) begin
         nxt[12'h341] = p;
         nxt[12'h342] = irq_c ? 64'h8000_0000_0000_0007 : 64'd11;
         nxt[12'h300] = (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
      end else if (v && st == 2'd3) begin
         nxt[12'h300] = (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
      end else if (v && st == 2'd1 && (f3 == 3'd1 || f3 == 3'd2) && m.exists(a) && a != 12'h344) begin
         nxt[a] = (f3 == 3'd1) ? d : (m[a] | d);
      end

      if (sel != 0) begin
         #2;
         case (sel)
            1: check({nm, "_rdata"}, rdata, want);
            2: check({nm, "_redirect_pc"}, redirect_pc, want);
            default: check({nm, "_irq_taken"}, {63'd0, irq_taken}, want);
         endcase
      end
      @(posedge clk);
      m = nxt;
      if (r) model_reset();
      #1;
   endtask

   task automatic peek(input logic [11:0] a, input logic [63:0] want, input string nm);
      issue(1'b0, 1'b1, 2'd0, 3'd0, a, 64'd0, 64'd0, 1'b0, 1, want, nm);
   endtask

   task automatic rw(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] d);
      issue(1'b0, 1'b1, 2'd1, f3, a, d, 64'd0, 1'b0, 0, 64'd0, "rw");
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         check("sb_rdata", rdata, me.rdata);
         check("sb_redirect", {63'd0, redirect}, {63'd0, me.redirect});
         check("sb_irq_taken", {63'd0, irq_taken}, {63'd0, me.irq});
         if (me.redirect) check("sb_redirect_pc", redirect_pc, me.rpc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   logic [11:0] alist [0:7] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hb00};

   initial begin
      rst = 1'b1; valid = 1'b0; state = 2'd0; funct3 = 3'd0; addr = 12'h0;
      rs1 = 64'd0; pc = 64'd0; timer = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      peek(12'h300, 64'h1800, "reset_mstatus");
      for (int i = 0; i < 9; i++)
         issue(1'b0, 1'b0, 2'd0, 3'd0, 12'hb00, 64'd0, 64'd0, 1'b0, 0, 64'd0, "idle");
      peek(12'hb00, 64'd10, "mcycle_10");

      rw(3'd1, 12'h305, 64'h8000_0100);
      issue(1'b0, 1'b1, 2'd2, 3'd0, 12'h0, 64'd0, 64'h8000_0040, 1'b0, 2, 64'h8000_0100, "ecall");
      peek(12'h341, 64'h8000_0040, "ecall_mepc");
      peek(12'h342, 64'd11, "ecall_mcause");
      peek(12'h300, 64'h1800, "ecall_mstatus");

      rw(3'd2, 12'h300, 64'h8);
      rw(3'd1, 12'h341, 64'h8000_0044);
      issue(1'b0, 1'b1, 2'd3, 3'd0, 12'h0, 64'd0, 64'h8000_0050, 1'b0, 2, 64'h8000_0044, "mret");
      peek(12'h300, 64'h1880, "mret_mstatus");

      rw(3'd2, 12'h300, 64'h8);
      rw(3'd1, 12'h304, 64'h80);
      rw(3'd1, 12'h340, 64'h1234);
      issue(1'b0, 1'b1, 2'd0, 3'd0, 12'h0, 64'd0, 64'd0, 1'b1, 0, 64'd0, "timer_rise");
      issue(1'b0, 1'b1, 2'd1, 3'd1, 12'h340, 64'hdead, 64'h8000_0080, 1'b1, 3, 64'd1, "irq");
      peek(12'h340, 64'h1234, "irq_mscratch");
      peek(12'h342, 64'h8000_0000_0000_0007, "irq_mcause");
      peek(12'h300, 64'h1880, "irq_mstatus");

      rw(3'd1, 12'hb00, 64'hffff_ffff_ffff_ffff);
      peek(12'hb00, 64'hffff_ffff_ffff_ffff, "mcycle_max");
      peek(12'hb00, 64'd0, "mcycle_wrap");
      rw(3'd1, 12'h344, 64'hffff_ffff_ffff_ffff);
      peek(12'h344, 64'd0, "mip_wr_ignored");
      issue(1'b0, 1'b0, 2'd0, 3'd0, 12'h0, 64'd0, 64'd0, 1'b1, 0, 64'd0, "timer");
      peek(12'h344, 64'h80, "mip_mtip");

      issue(1'b1, 1'b1, 2'd2, 3'd0, 12'h341, 64'd0, 64'h8000_0200, 1'b0, 0, 64'd0, "rst_ecall");
      peek(12'hb00, 64'd0, "rst_mcycle");
      peek(12'h341, 64'd0, "rst_mepc");
      peek(12'h300, 64'h1800, "rst_mstatus");

      for (int i = 0; i < 400; i++) begin
         logic [2:0] f3;
         logic [11:0] a;
         logic [63:0] d;
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : (($urandom_range(0, 1) == 1) ? 3'd1 : 3'd2);
         a = ($urandom_range(0, 8) == 8) ? 12'($urandom) : alist[$urandom_range(0, 7)];
         d = ($urandom_range(0, 3) == 0) ? 64'h88 : {$urandom, $urandom};
         issue($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), f3, a, d,
               {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 64'd0, "rand");
      end

      rst = 1'b0; valid = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
